// File: rtl/rl_pair_generator.sv
// Particle-pair source: reads one home-cell reference position, then sweeps neighbor indices
// across all filter lanes in lockstep, stalling on any back pressure and draining between references.
module rl_pair_generator #(
   parameter int DATA_WIDTH        = 32,
   parameter int PARTICLE_ID_WIDTH = 7,
   parameter int NUM_FILTER        = 7,
   parameter int HOME_LANE         = 0,
   parameter int DRAIN_MIN         = 2
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          start,
   input  logic [PARTICLE_ID_WIDTH-1:0]                  ref_particle_num,
   input  logic [NUM_FILTER-1:0][PARTICLE_ID_WIDTH-1:0]  nb_particle_num,
   input  logic [NUM_FILTER-1:0]                         back_pressure,
   input  logic                                          all_buffer_empty,
   output logic                                          ref_rd_en,
   output logic [PARTICLE_ID_WIDTH-1:0]                  ref_rd_addr,
   input  logic [3*DATA_WIDTH-1:0]                       ref_rd_data,
   output logic                                          nb_rd_en,
   output logic [PARTICLE_ID_WIDTH-1:0]                  nb_rd_addr,
   input  logic [NUM_FILTER-1:0][3*DATA_WIDTH-1:0]       nb_rd_data,
   output logic [NUM_FILTER-1:0]                         pair_valid,
   output logic [PARTICLE_ID_WIDTH-1:0]                  ref_particle_id,
   output logic [PARTICLE_ID_WIDTH-1:0]                  nb_particle_id,
   output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0]         ref_x,
   output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0]         ref_y,
   output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0]         ref_z,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]              nb_x,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]              nb_y,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]              nb_z,
   output logic                                          busy,
   output logic                                          done
);

   localparam int DCW = (DRAIN_MIN < 2) ? 1 : $clog2(DRAIN_MIN + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REF_RD  = 3'd1,
      REF_CAP = 3'd2,
      ISSUE   = 3'd3,
      DRAIN   = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                                         state;
   state_t                                         state_nxt;
   logic [PARTICLE_ID_WIDTH-1:0]                   ref_num_q;
   logic [NUM_FILTER-1:0][PARTICLE_ID_WIDTH-1:0]   nb_num_q;
   logic [PARTICLE_ID_WIDTH-1:0]                   ref_idx;
   logic [PARTICLE_ID_WIDTH-1:0]                   ref_idx_inc;
   logic [PARTICLE_ID_WIDTH-1:0]                   nb_idx;
   logic [PARTICLE_ID_WIDTH-1:0]                   nb_max;
   logic [PARTICLE_ID_WIDTH-1:0]                   nb_max_q;
   logic [DCW-1:0]                                 drain_cnt;
   logic [3*DATA_WIDTH-1:0]                        ref_pos_q;
   logic                                           pair_present;
   logic [NUM_FILTER-1:0]                          lane_vld;
   logic                                           issue;
   logic                                           last_issue;
   logic                                           drain_ok;
   logic                                           drain_exit;

   assign issue       = (state == ISSUE) && !(|back_pressure);
   assign last_issue  = (nb_idx == nb_max_q - 1'b1);
   assign drain_ok    = ((int'(drain_cnt) + 1) >= DRAIN_MIN);
   assign drain_exit  = (state == DRAIN) && drain_ok && all_buffer_empty;
   assign ref_idx_inc = ref_idx + 1'b1;

   always_comb begin
      nb_max = '0;
      for (int i = 0; i < NUM_FILTER; i++) begin
         if (nb_num_q[i] > nb_max) nb_max = nb_num_q[i];
      end
   end

   // Home-cell lane must never pair a particle with itself.
   always_comb begin
      lane_vld = '0;
      for (int i = 0; i < NUM_FILTER; i++) begin
         lane_vld[i] = (nb_idx < nb_num_q[i]) && !((i == HOME_LANE) && (nb_idx == ref_idx));
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (ref_particle_num == '0) ? DONE : REF_RD;
         REF_RD:  state_nxt = REF_CAP;
         REF_CAP: state_nxt = (nb_max == '0) ? DRAIN : ISSUE;
         ISSUE:   if (issue && last_issue) state_nxt = DRAIN;
         DRAIN:   if (drain_exit) state_nxt = (ref_idx_inc == ref_num_q) ? DONE : REF_RD;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         ref_num_q       <= '0;
         nb_num_q        <= '0;
         ref_idx         <= '0;
         nb_idx          <= '0;
         nb_max_q        <= '0;
         drain_cnt       <= '0;
         ref_pos_q       <= '0;
         ref_particle_id <= '0;
         nb_particle_id  <= '0;
         pair_valid      <= '0;
         pair_present    <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && start) begin
            ref_num_q <= ref_particle_num;
            nb_num_q  <= nb_particle_num;
            ref_idx   <= '0;
         end
         if (state == REF_CAP) begin
            ref_pos_q       <= ref_rd_data;
            ref_particle_id <= ref_idx;
            nb_idx          <= '0;
            nb_max_q        <= nb_max;
         end
         if (issue) begin
            nb_idx         <= nb_idx + 1'b1;
            nb_particle_id <= nb_idx;
         end
         if (state != DRAIN) drain_cnt <= '0;
         else if (!drain_ok) drain_cnt <= drain_cnt + 1'b1;
         if (drain_exit) ref_idx <= ref_idx_inc;
         // A stalled cycle presents nothing; in-flight pairs are never retracted.
         pair_valid   <= issue ? lane_vld : '0;
         pair_present <= issue;
      end
   end

   assign ref_rd_en   = (state == REF_RD);
   assign ref_rd_addr = ref_rd_en ? ref_idx : '0;
   assign nb_rd_en    = issue;
   assign nb_rd_addr  = issue ? nb_idx : '0;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

   for (genvar g = 0; g < NUM_FILTER; g++) begin : g_lane
      assign ref_x[g] = ref_pos_q[DATA_WIDTH-1:0];
      assign ref_y[g] = ref_pos_q[2*DATA_WIDTH-1:DATA_WIDTH];
      assign ref_z[g] = ref_pos_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
      assign nb_x[g*DATA_WIDTH +: DATA_WIDTH] = pair_present ? nb_rd_data[g][DATA_WIDTH-1:0] : '0;
      assign nb_y[g*DATA_WIDTH +: DATA_WIDTH] = pair_present ? nb_rd_data[g][2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      assign nb_z[g*DATA_WIDTH +: DATA_WIDTH] = pair_present ? nb_rd_data[g][3*DATA_WIDTH-1:2*DATA_WIDTH] : '0;
   end

endmodule

// File: tb/tb_rl_pair_generator.sv
// Bench for rl_pair_generator: cache models, scripted and random sweeps checked against a pair-list model.
module tb_rl_pair_generator;
   localparam int DW   = 32;
   localparam int PW   = 7;
   localparam int NF   = 7;
   localparam int HOME = 0;
   localparam int MAXC = 1024;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     start = 1'b0;
   logic [PW-1:0]            ref_particle_num = '0;
   logic [NF-1:0][PW-1:0]    nb_particle_num = '0;
   logic [NF-1:0]            back_pressure = '0;
   logic                     all_buffer_empty = 1'b1;
   logic                     ref_rd_en;
   logic [PW-1:0]            ref_rd_addr;
   logic [3*DW-1:0]          ref_rd_data = '0;
   logic                     nb_rd_en;
   logic [PW-1:0]            nb_rd_addr;
   logic [NF-1:0][3*DW-1:0]  nb_rd_data = '0;
   logic [NF-1:0]            pair_valid;
   logic [PW-1:0]            ref_particle_id, nb_particle_id;
   logic [NF-1:0][DW-1:0]    ref_x, ref_y, ref_z;
   logic [NF*DW-1:0]         nb_x, nb_y, nb_z;
   logic                     busy, done;

   rl_pair_generator #(.DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(PW), .NUM_FILTER(NF),
                       .HOME_LANE(HOME), .DRAIN_MIN(2)) dut (
      .clk(clk), .rst(rst), .start(start), .ref_particle_num(ref_particle_num),
      .nb_particle_num(nb_particle_num), .back_pressure(back_pressure),
      .all_buffer_empty(all_buffer_empty), .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr),
      .ref_rd_data(ref_rd_data), .nb_rd_en(nb_rd_en), .nb_rd_addr(nb_rd_addr),
      .nb_rd_data(nb_rd_data), .pair_valid(pair_valid), .ref_particle_id(ref_particle_id),
      .nb_particle_id(nb_particle_id), .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z),
      .nb_x(nb_x), .nb_y(nb_y), .nb_z(nb_z), .busy(busy), .done(done));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] seed = 32'h1357_2468;

   function automatic logic [31:0] rpos(input int idx, input int c);
      return seed ^ (32'(idx) * 32'h9E37_79B1) ^ (32'(c) << 28) ^ 32'h0000_1234;
   endfunction

   function automatic logic [31:0] npos(input int lane, input int idx, input int c);
      return (seed + 32'h5BD1_E995) ^ (32'(idx) * 32'h9E37_79B1) ^ (32'(lane) << 20) ^ (32'(c) << 28);
   endfunction

   // Home and neighbor position caches, one-cycle read latency.
   always @(posedge clk) begin
      if (ref_rd_en)
         ref_rd_data <= {rpos(int'(ref_rd_addr), 2), rpos(int'(ref_rd_addr), 1), rpos(int'(ref_rd_addr), 0)};
      if (nb_rd_en)
         for (int i = 0; i < NF; i++)
            nb_rd_data[i] <= {npos(i, int'(nb_rd_addr), 2), npos(i, int'(nb_rd_addr), 1), npos(i, int'(nb_rd_addr), 0)};
   end

   // Sweep configuration and drive modes.
   int cfg_ref;
   int cfg_nb [NF];
   int bp_mode, bp_start, empty_mode, empty_lo_start, empty_lo_end;

   // Observations of one sweep.
   logic [3*PW-1:0] obs_q[$];
   logic [3*PW-1:0] exp_q[$];
   logic [PW-1:0]   issue_addr_q[$];
   logic [PW-1:0]   hist_ref_id [MAXC];
   logic [DW-1:0]   hist_ref_x  [MAXC];
   logic            hist_ref_rd [MAXC];
   int done_cycle, done_count, issue_count, first_pv_cycle, data_err, stall_viol, timed_out;

   function automatic int model_nb_max();
      int m = 0;
      for (int i = 0; i < NF; i++) if (cfg_nb[i] > m) m = cfg_nb[i];
      return m;
   endfunction

   // Every (ref, nb) pair the sweep should present, in order, with the per-lane valid mask.
   function automatic void build_expected();
      int mx = model_nb_max();
      logic [NF-1:0] pv;
      exp_q.delete();
      for (int r = 0; r < cfg_ref; r++)
         for (int n = 0; n < mx; n++) begin
            pv = '0;
            for (int i = 0; i < NF; i++) pv[i] = (n < cfg_nb[i]) && !(i == HOME && n == r);
            if (pv != '0) exp_q.push_back({7'(r), 7'(n), pv});
         end
   endfunction

   function automatic int seq_mismatch();
      int m, lim;
      m = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
      lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++) if (obs_q[i] !== exp_q[i]) m++;
      return m;
   endfunction

   task automatic run_sweep();
      int stop;
      obs_q.delete();
      issue_addr_q.delete();
      done_cycle = -1; done_count = 0; issue_count = 0; first_pv_cycle = -1;
      data_err = 0; stall_viol = 0; timed_out = 0;
      ref_particle_num = 7'(cfg_ref);
      for (int i = 0; i < NF; i++) nb_particle_num[i] = 7'(cfg_nb[i]);
      build_expected();
      @(posedge clk); #1;
      start = 1'b1;
      stop = MAXC;
      for (int cyc = 0; cyc < stop; cyc++) begin
         if (cyc > 0) begin @(posedge clk); #1; start = 1'b0; end
         case (bp_mode)
            1:       back_pressure = ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, NF - 1)) : '0;
            2:       back_pressure = (cyc >= bp_start && cyc < bp_start + 4) ? 7'b000_1000 : '0;
            default: back_pressure = '0;
         endcase
         case (empty_mode)
            1:       all_buffer_empty = ($urandom_range(0, 2) != 0);
            2:       all_buffer_empty = !(cyc >= empty_lo_start && cyc <= empty_lo_end);
            default: all_buffer_empty = 1'b1;
         endcase
         @(negedge clk);
         hist_ref_id[cyc] = ref_particle_id;
         hist_ref_x[cyc]  = ref_x[0];
         hist_ref_rd[cyc] = ref_rd_en;
         if (nb_rd_en) begin
            issue_count++;
            issue_addr_q.push_back(nb_rd_addr);
            if (|back_pressure) stall_viol++;
         end
         if (|pair_valid) begin
            if (first_pv_cycle < 0) first_pv_cycle = cyc;
            obs_q.push_back({ref_particle_id, nb_particle_id, pair_valid});
            for (int i = 0; i < NF; i++) begin
               if (ref_x[i] !== rpos(int'(ref_particle_id), 0) || ref_y[i] !== rpos(int'(ref_particle_id), 1) ||
                   ref_z[i] !== rpos(int'(ref_particle_id), 2)) data_err++;
               if (pair_valid[i] &&
                   (nb_x[i*DW +: DW] !== npos(i, int'(nb_particle_id), 0) ||
                    nb_y[i*DW +: DW] !== npos(i, int'(nb_particle_id), 1) ||
                    nb_z[i*DW +: DW] !== npos(i, int'(nb_particle_id), 2))) data_err++;
            end
         end
         if (done) begin
            done_count++;
            if (done_cycle < 0) begin done_cycle = cyc; stop = cyc + 4; end
         end
      end
      if (done_cycle < 0) timed_out = 1;
      start = 1'b0; back_pressure = '0; all_buffer_empty = 1'b1;
   endtask

   task automatic set_all_nb(input int v);
      for (int i = 0; i < NF; i++) cfg_nb[i] = v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({busy, done, pair_valid, ref_rd_en, nb_rd_en, ref_rd_addr, nb_rd_addr, ref_particle_id, nb_particle_id} !== '0) begin
         n_fail++; $display("FAIL reset_ctrl: got busy=%b done=%b pv=%b ref_id=%0d nb_id=%0d, required all 0",
                            busy, done, pair_valid, ref_particle_id, nb_particle_id);
      end
      n_tests++;
      if ({ref_x, ref_y, ref_z} !== '0) begin
         n_fail++; $display("FAIL reset_ref_pos: got ref_x0=%h, required 0", ref_x[0]);
      end
      n_tests++;
      if ({nb_x, nb_y, nb_z} !== '0) begin
         n_fail++; $display("FAIL reset_nb_pos: got nb_x lane0=%h, required 0", nb_x[DW-1:0]);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      cfg_ref = 2; set_all_nb(3); bp_mode = 0; empty_mode = 0;
      run_sweep();
      n_tests++;
      if (timed_out !== 0) begin n_fail++; $display("FAIL basic_timeout: no done within %0d cycles", MAXC); end
      n_tests++;
      if (seq_mismatch() !== 0) begin
         n_fail++; $display("FAIL basic_pairs: %0d mismatches, got %0d pairs, required %0d", seq_mismatch(), obs_q.size(), exp_q.size());
      end
      n_tests++;
      if (data_err !== 0) begin n_fail++; $display("FAIL basic_data: %0d position errors, required 0", data_err); end
      n_tests++;
      if (first_pv_cycle !== 4) begin n_fail++; $display("FAIL basic_first_pair: cycle %0d, required 4", first_pv_cycle); end
      n_tests++;
      if (done_cycle !== 15) begin n_fail++; $display("FAIL basic_done_cycle: cycle %0d, required 15", done_cycle); end
      n_tests++;
      if (done_count !== 1) begin n_fail++; $display("FAIL basic_done_count: %0d, required 1", done_count); end
      n_tests++;
      if (issue_count !== 6) begin n_fail++; $display("FAIL basic_issues: %0d, required 6", issue_count); end
      n_tests++;
      if (hist_ref_id[5] !== 7'd0 || hist_ref_id[12] !== 7'd1) begin
         n_fail++; $display("FAIL basic_ref_id: got %0d then %0d, required 0 then 1", hist_ref_id[5], hist_ref_id[12]);
      end
   endtask

   task automatic test_unequal();
      logic [NF-1:0] seen;
      cfg_ref = 1; set_all_nb(0); cfg_nb[0] = 3; cfg_nb[1] = 1; bp_mode = 0; empty_mode = 0;
      run_sweep();
      seen = '0;
      foreach (obs_q[k]) seen |= obs_q[k][NF-1:0];
      n_tests++;
      if (seq_mismatch() !== 0) begin
         n_fail++; $display("FAIL unequal_pairs: %0d mismatches, got %0d pairs, required %0d", seq_mismatch(), obs_q.size(), exp_q.size());
      end
      n_tests++;
      if (seen[2] !== 1'b0) begin n_fail++; $display("FAIL unequal_lane2: lane 2 valid seen=%b, required 0", seen[2]); end
      n_tests++;
      if (issue_count !== 3) begin n_fail++; $display("FAIL unequal_sweep_len: %0d issues, required 3", issue_count); end
      n_tests++;
      if (done_cycle !== 8) begin n_fail++; $display("FAIL unequal_done_cycle: cycle %0d, required 8", done_cycle); end
   endtask

   task automatic test_back_pressure();
      int addr_err;
      cfg_ref = 1; set_all_nb(6); bp_mode = 2; bp_start = 5; empty_mode = 0;
      run_sweep();
      addr_err = (issue_addr_q.size() != 6) ? 1 : 0;
      foreach (issue_addr_q[k]) if (issue_addr_q[k] !== 7'(k)) addr_err++;
      n_tests++;
      if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stall: %0d issues under back pressure, required 0", stall_viol); end
      n_tests++;
      if (addr_err !== 0) begin
         n_fail++; $display("FAIL bp_addr_seq: %0d address errors over %0d issues, required 0 over 6", addr_err, issue_addr_q.size());
      end
      n_tests++;
      if (seq_mismatch() !== 0) begin n_fail++; $display("FAIL bp_pairs: %0d mismatches, required 0", seq_mismatch()); end
      n_tests++;
      if (done_cycle !== 15) begin n_fail++; $display("FAIL bp_done_cycle: cycle %0d, required 15", done_cycle); end
      bp_mode = 0;
   endtask

   task automatic test_drain_hold();
      int hold_err, next_rd;
      cfg_ref = 2; set_all_nb(3); bp_mode = 0; empty_mode = 2; empty_lo_start = 6; empty_lo_end = 15;
      run_sweep();
      hold_err = 0;
      for (int c = 4; c <= 16; c++)
         if (hist_ref_id[c] !== 7'd0 || hist_ref_x[c] !== rpos(0, 0)) hold_err++;
      next_rd = -1;
      for (int c = 2; c < 40; c++) if (next_rd < 0 && hist_ref_rd[c] === 1'b1) next_rd = c;
      n_tests++;
      if (hold_err !== 0) begin n_fail++; $display("FAIL drain_ref_stable: %0d cycles with changed ref, required 0", hold_err); end
      n_tests++;
      if (next_rd !== 17) begin n_fail++; $display("FAIL drain_next_rd: cycle %0d, required 17", next_rd); end
      n_tests++;
      if (done_cycle !== 24) begin n_fail++; $display("FAIL drain_done_cycle: cycle %0d, required 24", done_cycle); end
      n_tests++;
      if (seq_mismatch() !== 0) begin n_fail++; $display("FAIL drain_pairs: %0d mismatches, required 0", seq_mismatch()); end
      empty_mode = 0;
   endtask

   task automatic test_zero_counts();
      cfg_ref = 0; set_all_nb(4); bp_mode = 0; empty_mode = 0;
      run_sweep();
      n_tests++;
      if (done_cycle !== 1) begin n_fail++; $display("FAIL zero_ref_done: cycle %0d, required 1", done_cycle); end
      n_tests++;
      if (obs_q.size() !== 0 || issue_count !== 0) begin
         n_fail++; $display("FAIL zero_ref_activity: %0d pairs %0d issues, required 0 and 0", obs_q.size(), issue_count);
      end
      cfg_ref = 1; set_all_nb(0);
      run_sweep();
      n_tests++;
      if (obs_q.size() !== 0 || issue_count !== 0) begin
         n_fail++; $display("FAIL zero_nb_activity: %0d pairs %0d issues, required 0 and 0", obs_q.size(), issue_count);
      end
      n_tests++;
      if (done_cycle !== 5 || hist_ref_rd[1] !== 1'b1) begin
         n_fail++; $display("FAIL zero_nb_done: done cycle %0d ref_rd@1=%b, required 5 and 1", done_cycle, hist_ref_rd[1]);
      end
   endtask

   task automatic test_reset_mid();
      ref_particle_num = 7'd2;
      for (int i = 0; i < NF; i++) nb_particle_num[i] = 7'd5;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (busy !== 1'b1 || nb_rd_en !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre_reset: busy=%b nb_rd_en=%b, required 1 and 1", busy, nb_rd_en);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({busy, done, pair_valid, ref_rd_en, nb_rd_en, ref_rd_addr, nb_rd_addr, ref_particle_id, nb_particle_id,
           ref_x, ref_y, ref_z, nb_x, nb_y, nb_z} !== '0) begin
         n_fail++; $display("FAIL mid_reset_outputs: busy=%b pv=%b nb_rd_en=%b ref_id=%0d, required all 0",
                            busy, pair_valid, nb_rd_en, ref_particle_id);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: busy=%b, required 0", busy); end
      cfg_ref = 2; set_all_nb(2); cfg_nb[0] = 5; cfg_nb[4] = 3; bp_mode = 0; empty_mode = 0;
      run_sweep();
      n_tests++;
      if (seq_mismatch() !== 0 || done_count !== 1 || data_err !== 0) begin
         n_fail++; $display("FAIL mid_resweep: %0d mismatches %0d done %0d data errors, required 0, 1, 0",
                            seq_mismatch(), done_count, data_err);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         seed = $urandom;
         cfg_ref = $urandom_range(1, 4);
         for (int i = 0; i < NF; i++) cfg_nb[i] = $urandom_range(0, 7);
         bp_mode = 1; empty_mode = 1;
         run_sweep();
         n_tests++;
         if (timed_out !== 0 || done_count !== 1) begin
            n_fail++; $display("FAIL rand%0d_done: timed_out=%0d done_count=%0d, required 0 and 1", it, timed_out, done_count);
         end
         n_tests++;
         if (seq_mismatch() !== 0) begin
            n_fail++; $display("FAIL rand%0d_pairs: %0d mismatches, got %0d pairs, required %0d", it, seq_mismatch(), obs_q.size(), exp_q.size());
         end
         n_tests++;
         if (issue_count !== cfg_ref * model_nb_max()) begin
            n_fail++; $display("FAIL rand%0d_issues: %0d, required %0d", it, issue_count, cfg_ref * model_nb_max());
         end
         n_tests++;
         if (data_err !== 0 || stall_viol !== 0) begin
            n_fail++; $display("FAIL rand%0d_data: %0d data errors %0d stall issues, required 0 and 0", it, data_err, stall_viol);
         end
      end
      bp_mode = 0; empty_mode = 0;
   endtask

   initial begin
      bp_mode = 0; empty_mode = 0; bp_start = 0; empty_lo_start = 0; empty_lo_end = 0;
      test_reset();
      test_basic();
      test_unequal();
      test_back_pressure();
      test_drain_hold();
      test_zero_counts();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
